rotary_step_controller: RTL
===========================

ROTARY_STEP_CONTROLLER -- requirements
Module: rotary_step_controller

Interface
REQ-001 Parameter LOCKOUT_CYCLES, default 16: idle cycles enforced after each accepted step; legal range 1..255.
REQ-002 Parameter LED_INIT, default 8'b0000_0001: LED pattern after reset, and the fallback pattern for a zero load.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port rotation_event  input  1  level from the encoder event detector, synchronous to clk; each rising edge requests one step.
REQ-006 Port rotation_direction  input  1  1 = rotate left (count up), 0 = rotate right (count down); sampled only when a step is accepted.
REQ-007 Port load  input  1  synchronous request to load led from load_value.
REQ-008 Port load_value  input  8  pattern loaded on load.
REQ-009 Port led  output  8  current LED pattern, registered.
REQ-010 Port step_count  output  8  up/down step counter, registered.
REQ-011 Port step_pulse  output  1  one-cycle high in the cycle after each accepted step.
REQ-012 Port dir_latched  output  1  direction of the most recent accepted step.
REQ-013 Port busy  output  1  high while in HOLD (lockout active).

Function
REQ-014 Edge detect: register ev_q <= rotation_event each cycle; rise = rotation_event & ~ev_q.
REQ-015 The FSM SHALL have two states: IDLE and HOLD, plus an 8-bit lockout counter lk_cnt.
REQ-016 In IDLE with rise=1 and load=0, at that edge: led rotates by one bit (left if rotation_direction=1, msb into lsb; right if 0, lsb into msb), step_count +1 (dir=1) or -1 (dir=0) mod 256, dir_latched <= rotation_direction, step_pulse <= 1, lk_cnt <= LOCKOUT_CYCLES, state -> HOLD.
REQ-017 Latency: led, step_count, dir_latched and step_pulse SHALL change at the first clock edge on which the rise is sampled (one-edge latency).
REQ-018 step_pulse SHALL be high for exactly one cycle per accepted step and low otherwise.
REQ-019 In HOLD, lk_cnt decrements each cycle; when lk_cnt reaches 1 the state returns to IDLE at the next edge, giving exactly LOCKOUT_CYCLES cycles with busy=1.
REQ-020 A rise occurring in HOLD SHALL be discarded; it is neither queued nor counted.
REQ-021 A rise in the first IDLE cycle after HOLD SHALL be accepted normally.
REQ-022 load=1 in any state: led <= load_value, or LED_INIT when load_value = 0; step_count <= 0; state and lk_cnt unchanged.
REQ-023 load and an IDLE rise in the same cycle: load wins and the step is dropped (no rotation, no step_pulse, state stays IDLE).
REQ-024 step_count wraps: 255 +1 -> 0, and 0 -1 -> 255.
REQ-025 led SHALL never be all-zero after reset.

Reset
REQ-026 rst=1 asynchronously sets: state=IDLE, lk_cnt=0, led=LED_INIT, step_count=0, step_pulse=0, dir_latched=0, busy=0.
REQ-027 ev_q SHALL reset to 1, so that a rotation_event held high across reset release does not produce a step.
REQ-028 Reset asserted mid-HOLD SHALL abort the lockout immediately, and the first rise after release SHALL be accepted.

Verification
REQ-029 Reset, then rotation_event 0->1 with direction=1 -> next edge: led=0x02, step_count=1, step_pulse high for 1 cycle, busy high for 16 cycles.
REQ-030 Starting from led=0x01, one step with direction=0 -> led=0x80, step_count=255, dir_latched=0.
REQ-031 Second rise 5 cycles after an accepted step (LOCKOUT_CYCLES=16) -> ignored; led and step_count unchanged, no step_pulse.
REQ-032 load=1 with load_value=0x00 in the same cycle as a rise -> led=LED_INIT, step_count=0, no step_pulse, busy stays 0.
REQ-033 rotation_event held at 1 through reset release -> no step until it falls and rises again.
REQ-034 Assert rst during HOLD, release, then rise with direction=1 -> step accepted: led=0x02, step_count=1.

Source files
------------

// File: rtl/rotary_step_controller.sv
// Rotary-encoder step controller: rotates an LED pattern and tracks a step count
// on each accepted encoder event, with a fixed lockout window after every step.
module rotary_step_controller #(
    parameter int unsigned LOCKOUT_CYCLES = 16,
    parameter logic [7:0]  LED_INIT       = 8'b0000_0001
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rotation_event,
    input  logic       rotation_direction,
    input  logic       load,
    input  logic [7:0] load_value,
    output logic [7:0] led,
    output logic [7:0] step_count,
    output logic       step_pulse,
    output logic       dir_latched,
    output logic       busy
);

    localparam logic [7:0] LOCKOUT_LD = 8'(LOCKOUT_CYCLES);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] lk_cnt;
    logic [7:0] lk_cnt_nxt;
    logic       ev_q;
    logic       rise;
    logic       accept;

    function automatic logic [7:0] rotate(input logic [7:0] pat, input logic left);
        rotate = left ? {pat[6:0], pat[7]} : {pat[0], pat[7:1]};
    endfunction

    function automatic logic [7:0] load_pattern(input logic [7:0] val);
        load_pattern = (val == 8'd0) ? LED_INIT : val;
    endfunction

    assign rise   = rotation_event & ~ev_q;
    // A simultaneous load takes priority and swallows the step.
    assign accept = (state == IDLE) && rise && !load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            lk_cnt <= 8'd0;
        end else begin
            state  <= state_nxt;
            lk_cnt <= lk_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        lk_cnt_nxt = lk_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt  = HOLD;
                    lk_cnt_nxt = LOCKOUT_LD;
                end
            end
            HOLD: begin
                lk_cnt_nxt = lk_cnt - 8'd1;
                if (lk_cnt <= 8'd1)
                    state_nxt = IDLE;
            end
            default: begin
                state_nxt  = IDLE;
                lk_cnt_nxt = 8'd0;
            end
        endcase
    end

    always_comb begin
        busy = (state == HOLD);
    end

    // ev_q resets high so an event level held through reset release is not a rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ev_q        <= 1'b1;
            led         <= LED_INIT;
            step_count  <= 8'd0;
            step_pulse  <= 1'b0;
            dir_latched <= 1'b0;
        end else begin
            ev_q       <= rotation_event;
            step_pulse <= accept;
            if (load) begin
                led        <= load_pattern(load_value);
                step_count <= 8'd0;
            end else if (accept) begin
                led         <= rotate(led, rotation_direction);
                step_count  <= rotation_direction ? step_count + 8'd1 : step_count - 8'd1;
                dir_latched <= rotation_direction;
            end
        end
    end

endmodule
